// File: rtl/data_mem_responder.sv
// Data-memory responder for the memory stage: 16-bit word array serving
// single-cycle 16-bit and two-cycle 32-bit (high word first) load/store requests.
module data_mem_responder #(
    parameter int DEPTH = 4096
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic        i_en32,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SECOND,
        ACK
    } state_t;

    state_t state;

    logic [15:0]   mem [DEPTH];

    logic          rd_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_lo_q;
    logic [15:0]   rdata_hi_q;

    logic          accept;
    logic          req_fault;
    logic [32:0]   addr_ext;
    logic [32:0]   addr_next_ext;
    logic [AW-1:0] rd_addr;
    logic [15:0]   mem_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    // The +1 is taken at 33 bits so an address of all ones cannot wrap to 0
    // and sneak past the bounds check of a 32-bit access.
    always_comb begin
        addr_ext      = {1'b0, i_addr};
        addr_next_ext = addr_ext + 33'd1;
        req_fault     = (i_rd && i_wr)
                      || (addr_ext >= DEPTH_EXT)
                      || (i_en32 && (addr_next_ext >= DEPTH_EXT));
        accept        = (state == IDLE) && i_req && !i_reset;
    end

    always_comb begin
        rd_addr   = (state == SECOND) ? (addr_q + AW'(1)) : i_addr[AW-1:0];
        mem_rdata = mem[rd_addr];
    end

    // First access happens on the accepting edge straight from the inputs;
    // the second word uses only latched values so input changes cannot leak in.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = i_addr[AW-1:0];
        mem_wdata = i_en32 ? i_wdata[31:16] : i_wdata[15:0];
        if (accept && !req_fault && i_wr) begin
            mem_we = 1'b1;
        end else if ((state == SECOND) && wr_q && !i_reset) begin
            mem_we    = 1'b1;
            mem_waddr = addr_q + AW'(1);
            mem_wdata = wdata_lo_q;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= IDLE;
            o_ready    <= 1'b1;
            o_ack      <= 1'b0;
            o_rdata    <= 32'h0;
            o_fault    <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_lo_q <= 16'h0;
            rdata_hi_q <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    o_ack <= 1'b0;
                    if (i_req) begin
                        rd_q       <= i_rd;
                        wr_q       <= i_wr;
                        addr_q     <= i_addr[AW-1:0];
                        wdata_lo_q <= i_wdata[15:0];
                        o_ready    <= 1'b0;
                        if (req_fault) begin
                            o_fault <= 1'b1;
                            o_rdata <= 32'h0;
                            o_ack   <= 1'b1;
                            state   <= ACK;
                        end else if (i_en32) begin
                            o_fault    <= 1'b0;
                            rdata_hi_q <= i_rd ? mem_rdata : 16'h0;
                            state      <= SECOND;
                        end else begin
                            o_fault <= 1'b0;
                            o_rdata <= i_rd ? {16'h0, mem_rdata} : 32'h0;
                            o_ack   <= 1'b1;
                            state   <= ACK;
                        end
                    end
                end

                SECOND: begin
                    o_rdata <= rd_q ? {rdata_hi_q, mem_rdata} : 32'h0;
                    o_ack   <= 1'b1;
                    state   <= ACK;
                end

                ACK: begin
                    o_ack   <= 1'b0;
                    o_ready <= 1'b1;
                    o_fault <= 1'b0;
                    o_rdata <= 32'h0;
                    state   <= IDLE;
                end

                default: begin
                    o_ack   <= 1'b0;
                    o_ready <= 1'b1;
                    o_fault <= 1'b0;
                    o_rdata <= 32'h0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: round trips, bounds faults,
// busy-ignore behaviour and reset in the middle of a transaction.
module tb_data_mem_responder;

    logic        clk;
    logic        i_reset;
    logic        i_req;
    logic        i_rd;
    logic        i_wr;
    logic        i_en32;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_ack;
    logic [31:0] o_rdata;
    logic        o_fault;

    int checkCount = 0;
    int errorCount = 0;

    data_mem_responder #(.DEPTH(4096)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .i_req   (i_req),
        .i_rd    (i_rd),
        .i_wr    (i_wr),
        .i_en32  (i_en32),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .o_ready (o_ready),
        .o_ack   (o_ack),
        .o_rdata (o_rdata),
        .o_fault (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request from a negedge in IDLE, returns ack latency (-1 on
    // timeout) and the response, then waits for o_ready to come back.
    task automatic applyStimulus(input logic rd, input logic wr, input logic en32,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic [31:0] rdata,
                                 output logic fault);
        lat   = -1;
        rdata = 32'hDEADDEAD;
        fault = 1'bx;
        i_rd    = rd;
        i_wr    = wr;
        i_en32  = en32;
        i_addr  = addr;
        i_wdata = wdata;
        i_req   = 1'b1;
        @(posedge clk);
        #1;
        i_req   = 1'b0;
        i_addr  = 32'h5A5A5A5A;
        i_wdata = 32'hC3C3C3C3;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (o_ack) begin
                lat   = n;
                rdata = o_rdata;
                fault = o_fault;
                break;
            end
        end
        for (int n = 0; n < 8 && !o_ready; n++) begin
            @(negedge clk);
        end
    endtask

    task automatic doAccess(input string tag, input logic rd, input logic wr,
                            input logic en32, input logic [31:0] addr,
                            input logic [31:0] wdata, input int expLat,
                            input logic [31:0] expRdata, input logic expFault);
        int          lat;
        logic [31:0] rdata;
        logic        fault;
        applyStimulus(rd, wr, en32, addr, wdata, lat, rdata, fault);
        checkOutput({tag, "_lat"},   32'(lat),   32'(expLat));
        checkOutput({tag, "_rdata"}, rdata,      expRdata);
        checkOutput({tag, "_fault"}, 32'(fault), 32'(expFault));
    endtask

    initial begin
        i_reset = 1'b1;
        i_req   = 1'b0;
        i_rd    = 1'b0;
        i_wr    = 1'b0;
        i_en32  = 1'b0;
        i_addr  = 32'h0;
        i_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_ack",   32'(o_ack),   32'd0);
        checkOutput("rst_rdata", o_rdata,      32'h0);
        checkOutput("rst_fault", 32'(o_fault), 32'd0);
        i_reset = 1'b0;
        @(negedge clk);

        // 16-bit and 32-bit round trips
        doAccess("wr16_10",  0, 1, 0, 32'h10, 32'h0000ABCD, 1, 32'h0, 0);
        doAccess("rd16_10",  1, 0, 0, 32'h10, 32'h0,        1, 32'h0000ABCD, 0);
        doAccess("wr32_20",  0, 1, 1, 32'h20, 32'h12345678, 2, 32'h0, 0);
        doAccess("rd16_20",  1, 0, 0, 32'h20, 32'h0,        1, 32'h00001234, 0);
        doAccess("rd16_21",  1, 0, 0, 32'h21, 32'h0,        1, 32'h00005678, 0);
        doAccess("rd32_20",  1, 0, 1, 32'h20, 32'h0,        2, 32'h12345678, 0);

        // Bounds and malformed requests
        doAccess("wr16_fff", 0, 1, 0, 32'hFFF, 32'h0000BEEF, 1, 32'h0, 0);
        doAccess("rd32_fff", 1, 0, 1, 32'hFFF, 32'h0,        1, 32'h0, 1);
        doAccess("wr32_fff", 0, 1, 1, 32'hFFF, 32'h11112222, 1, 32'h0, 1);
        doAccess("rd16_fff", 1, 0, 0, 32'hFFF, 32'h0,        1, 32'h0000BEEF, 0);
        doAccess("rd32_max", 1, 0, 1, 32'hFFFFFFFF, 32'h0,   1, 32'h0, 1);
        doAccess("rd16_oob", 1, 0, 0, 32'h1000, 32'h0,       1, 32'h0, 1);
        doAccess("rdwr_10",  1, 1, 0, 32'h10, 32'h00009999,  1, 32'h0, 1);
        doAccess("rd16_10b", 1, 0, 0, 32'h10, 32'h0,         1, 32'h0000ABCD, 0);
        doAccess("noop_20",  0, 0, 0, 32'h20, 32'h0000FFFF,  1, 32'h0, 0);
        doAccess("rd16_20b", 1, 0, 0, 32'h20, 32'h0,         1, 32'h00001234, 0);

        // Busy/ignore: i_req held high while the address keeps changing
        i_rd = 1'b1; i_wr = 1'b0; i_en32 = 1'b1; i_addr = 32'h20; i_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("busy_ready_c1", 32'(o_ready), 32'd0);
        checkOutput("busy_ack_c1",   32'(o_ack),   32'd0);
        i_en32 = 1'b0; i_addr = 32'h10;
        @(negedge clk);
        checkOutput("busy_ack_c2",   32'(o_ack),   32'd1);
        checkOutput("busy_rdata_c2", o_rdata,      32'h12345678);
        i_addr = 32'h10;
        @(negedge clk);
        checkOutput("busy_ready_c3", 32'(o_ready), 32'd1);
        checkOutput("busy_ack_c3",   32'(o_ack),   32'd0);
        @(posedge clk);
        #1;
        i_req = 1'b0;
        @(negedge clk);
        checkOutput("busy_ack_c4",   32'(o_ack),   32'd1);
        checkOutput("busy_rdata_c4", o_rdata,      32'h0000ABCD);
        @(negedge clk);
        checkOutput("busy_ready_c5", 32'(o_ready), 32'd1);

        // Reset while in SECOND of a 32-bit write
        doAccess("pre_30", 0, 1, 0, 32'h30, 32'h0, 1, 32'h0, 0);
        doAccess("pre_31", 0, 1, 0, 32'h31, 32'h0, 1, 32'h0, 0);
        i_rd = 1'b0; i_wr = 1'b1; i_en32 = 1'b1; i_addr = 32'h30;
        i_wdata = 32'hAAAA5555; i_req = 1'b1;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        checkOutput("rst2nd_ack",   32'(o_ack),   32'd0);
        checkOutput("rst2nd_ready", 32'(o_ready), 32'd1);
        i_reset = 1'b0;
        @(negedge clk);
        checkOutput("rst2nd_ack2",  32'(o_ack),   32'd0);
        doAccess("rd16_30", 1, 0, 0, 32'h30, 32'h0, 1, 32'h0000AAAA, 0);
        doAccess("rd16_31", 1, 0, 0, 32'h31, 32'h0, 1, 32'h00000000, 0);

        // Reset in ACK drops o_ack at the reset edge
        i_rd = 1'b1; i_wr = 1'b0; i_en32 = 1'b0; i_addr = 32'h10; i_req = 1'b1;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        @(negedge clk);
        checkOutput("rstack_ack_pre", 32'(o_ack), 32'd1);
        i_reset = 1'b1;
        @(negedge clk);
        checkOutput("rstack_ack",  32'(o_ack),   32'd0);
        checkOutput("rstack_rdata", o_rdata,     32'h0);

        // Reset together with i_req: nothing accepted
        i_rd = 1'b0; i_wr = 1'b1; i_en32 = 1'b0; i_addr = 32'h10;
        i_wdata = 32'h00007777; i_req = 1'b1;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        i_reset = 1'b0;
        @(negedge clk);
        checkOutput("rstreq_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        checkOutput("rstreq_ack",   32'(o_ack),   32'd0);
        doAccess("rd16_10c", 1, 0, 0, 32'h10, 32'h0, 1, 32'h0000ABCD, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
